// File: rtl/sync_memory_pkg.sv
// Shared types and default sizing for the sync_memory block.
package sync_memory_pkg;

   localparam int DEFAULT_DATA_W = 8;
   localparam int DEFAULT_ADDR_W = 12;

   // Controller states: normal request service, or whole-array zero fill.
   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

endpackage

// File: rtl/sync_memory_mem_array.sv
// Storage array: one synchronous write port and one registered read port.
// The contents are never reset; only the read register is.
module mem_array #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_d;
   logic [DATA_W-1:0] rdata_q;

   // Next read data: sample the pre-write contents on a read, else hold.
   always_comb begin
      rdata_d = rdata_q;
      if (re) begin
         rdata_d = mem_q[raddr];
      end else begin
         rdata_d = rdata_q;
      end
   end

   // Array write; deliberately outside reset so contents survive it.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   // Read data register, cleared by reset and held between reads.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata_q <= {DATA_W{1'b0}};
      end else begin
         rdata_q <= rdata_d;
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/sync_memory.sv
// Single-port synchronous memory with a whole-array clear sequence.
// The controller arbitrates Read/Write/Clear and drives the handshake pulses.
module sync_memory
   import sync_memory_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W,
   parameter int ADDR_W = DEFAULT_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] Din,
   input  logic [ADDR_W-1:0] Address,
   input  logic              Read,
   input  logic              Write,
   input  logic              Clear,
   output logic [DATA_W-1:0] Dout,
   output logic              Dout_valid,
   output logic              Busy,
   output logic              Reject
);

   localparam logic [ADDR_W-1:0] CNT_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] CNT_LAST = {ADDR_W{1'b1}};

   state_t            state_d, state_q;
   logic [ADDR_W-1:0] clr_cnt_d, clr_cnt_q;
   logic              dout_valid_d, dout_valid_q;
   logic              reject_d, reject_q;

   logic              mem_we;
   logic              mem_re;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;

   // Next-state, clear counter, memory port controls and handshake pulses.
   always_comb begin
      state_d      = state_q;
      clr_cnt_d    = clr_cnt_q;
      dout_valid_d = 1'b0;
      reject_d     = 1'b0;
      mem_we       = 1'b0;
      mem_re       = 1'b0;
      mem_waddr    = Address;
      mem_wdata    = Din;
      case (state_q)
         IDLE: begin
            if (Clear) begin
               // Clear wins; a concurrent Read/Write is silently dropped.
               state_d   = CLEAR;
               clr_cnt_d = {ADDR_W{1'b0}};
            end else begin
               mem_we       = Write;
               mem_re       = Read;
               dout_valid_d = Read;
            end
         end
         CLEAR: begin
            mem_we    = 1'b1;
            mem_waddr = clr_cnt_q;
            mem_wdata = {DATA_W{1'b0}};
            reject_d  = Read | Write | Clear;
            clr_cnt_d = clr_cnt_q + CNT_ONE;
            if (clr_cnt_q == CNT_LAST) begin
               state_d = IDLE;
            end else begin
               state_d = CLEAR;
            end
         end
         default: begin
            state_d   = IDLE;
            clr_cnt_d = {ADDR_W{1'b0}};
         end
      endcase
   end

   // Controller registers; reset aborts any fill in progress.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         clr_cnt_q    <= {ADDR_W{1'b0}};
         dout_valid_q <= 1'b0;
         reject_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         clr_cnt_q    <= clr_cnt_d;
         dout_valid_q <= dout_valid_d;
         reject_q     <= reject_d;
      end
   end

   mem_array #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_mem_array (
      .clk   (clk),
      .rst   (rst),
      .we    (mem_we),
      .waddr (mem_waddr),
      .wdata (mem_wdata),
      .re    (mem_re),
      .raddr (Address),
      .rdata (Dout)
   );

   assign Dout_valid = dout_valid_q;
   assign Reject     = reject_q;
   assign Busy       = (state_q == CLEAR);

endmodule

// File: tb/tb_sync_memory.sv
// Randomized scoreboard bench for sync_memory against a behavioural model.
module tb_sync_memory;

   localparam int DW    = 8;
   localparam int AW    = 12;
   localparam int DEPTH = 4096;

   logic          clk;
   logic          rst;
   logic [DW-1:0] Din;
   logic [AW-1:0] Address;
   logic          Read;
   logic          Write;
   logic          Clear;
   logic [DW-1:0] Dout;
   logic          Dout_valid;
   logic          Busy;
   logic          Reject;

   sync_memory #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk        (clk),
      .rst        (rst),
      .Din        (Din),
      .Address    (Address),
      .Read       (Read),
      .Write      (Write),
      .Clear      (Clear),
      .Dout       (Dout),
      .Dout_valid (Dout_valid),
      .Busy       (Busy),
      .Reject     (Reject)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state
   logic [DW-1:0] ref_mem [DEPTH];
   logic [DW-1:0] exp_q [$];
   logic [DW-1:0] exp_dout;
   logic          exp_valid;
   logic          exp_reject;
   int            clr_left;      // words still to be zeroed, 0 when idle
   int            clr_next;      // next word the fill will zero
   int            checks = 0;
   int            errors = 0;
   int            busy_cycles = 0;

   // Model of one rising edge with the given request inputs.
   task automatic model_edge(input logic r, input logic w, input logic c,
                             input logic [AW-1:0] a, input logic [DW-1:0] d);
      exp_valid  = 1'b0;
      exp_reject = 1'b0;
      if (clr_left > 0) begin
         exp_reject = r | w | c;
         ref_mem[clr_next] = '0;
         clr_next = (clr_next + 1) % DEPTH;
         clr_left = clr_left - 1;
      end else if (c) begin
         clr_left = DEPTH;
         clr_next = 0;
      end else begin
         if (r) begin
            exp_q.push_back(ref_mem[a]);
            exp_valid = 1'b1;
         end
         if (w) ref_mem[a] = d;
      end
   endtask

   task automatic do_cycle(input logic r, input logic w, input logic c,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
      Read = r; Write = w; Clear = c; Address = a; Din = d;
      @(posedge clk);
      model_edge(r, w, c, a, d);
      #1;
   endtask

   task automatic idle_cycle();
      do_cycle(1'b0, 1'b0, 1'b0, '0, '0);
   endtask

   task automatic apply_reset(input int cycles);
      Read = 1'b0; Write = 1'b0; Clear = 1'b0;
      rst = 1'b1;
      clr_left = 0; clr_next = 0;
      exp_valid = 1'b0; exp_reject = 1'b0; exp_dout = '0;
      exp_q.delete();
      #1;
      checks++;
      if (Busy !== 1'b0 || Dout !== '0 || Dout_valid !== 1'b0 || Reject !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: Busy=%b Dout=%h Dout_valid=%b Reject=%b, required 0/00/0/0",
                  Busy, Dout, Dout_valid, Reject);
      end
      repeat (cycles) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Monitor: compare handshake outputs every cycle; pop scoreboard on valid data.
   always @(negedge clk) begin
      if (Busy) busy_cycles++;
      checks++;
      if (Busy !== (clr_left > 0)) begin
         errors++;
         $display("FAIL busy: got %b, required %b at %0t", Busy, (clr_left > 0), $time);
      end
      checks++;
      if (Reject !== exp_reject) begin
         errors++;
         $display("FAIL reject: got %b, required %b at %0t", Reject, exp_reject, $time);
      end
      checks++;
      if (Dout_valid !== exp_valid) begin
         errors++;
         $display("FAIL dout_valid: got %b, required %b at %0t", Dout_valid, exp_valid, $time);
      end
      if (Dout_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_data: Dout=%h with no read outstanding at %0t", Dout, $time);
         end else begin
            exp_dout = exp_q.pop_front();
         end
      end
      checks++;
      if (Dout !== exp_dout) begin
         errors++;
         $display("FAIL dout: got %h, required %h at %0t", Dout, exp_dout, $time);
      end
   end

   initial begin
      int normal;
      int guard;
      logic r, w, c;
      logic [AW-1:0] a;
      Read = 1'b0; Write = 1'b0; Clear = 1'b0; Address = '0; Din = '0;
      clr_left = 0; clr_next = 0;
      exp_valid = 1'b0; exp_reject = 1'b0; exp_dout = '0;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      rst = 1'b1;
      @(posedge clk);
      apply_reset(2);

      // Basic writes then reads, each read answered one cycle later.
      do_cycle(1'b0, 1'b1, 1'b0, 12'h000, 8'h05);
      do_cycle(1'b0, 1'b1, 1'b0, 12'h056, 8'h18);
      do_cycle(1'b0, 1'b1, 1'b0, 12'hFE1, 8'h3C);
      do_cycle(1'b1, 1'b0, 1'b0, 12'h000, 8'h00);
      do_cycle(1'b1, 1'b0, 1'b0, 12'h056, 8'h00);
      do_cycle(1'b1, 1'b0, 1'b0, 12'hFE1, 8'h00);
      idle_cycle();

      // Read-first collision, then read back the new value.
      do_cycle(1'b0, 1'b1, 1'b0, 12'h010, 8'hAA);
      do_cycle(1'b1, 1'b1, 1'b0, 12'h010, 8'h55);
      do_cycle(1'b1, 1'b0, 1'b0, 12'h010, 8'h00);
      idle_cycle();

      // Full clear with a rejected write 10 cycles in; Busy must last DEPTH cycles.
      busy_cycles = 0;
      do_cycle(1'b0, 1'b0, 1'b1, 12'h000, 8'h00);
      repeat (9) idle_cycle();
      do_cycle(1'b0, 1'b1, 1'b0, 12'h200, 8'h77);
      while (clr_left > 0) idle_cycle();
      @(negedge clk);
      checks++;
      if (busy_cycles != DEPTH) begin
         errors++;
         $display("FAIL busy_length: got %0d cycles, required %0d", busy_cycles, DEPTH);
      end
      #1;
      do_cycle(1'b1, 1'b0, 1'b0, 12'h056, 8'h00);
      do_cycle(1'b1, 1'b0, 1'b0, 12'h200, 8'h00);
      idle_cycle();

      // Clear and Read together: no data, no reject; then abort fill by reset.
      for (int i = 0; i < 200; i++) do_cycle(1'b0, 1'b1, 1'b0, i[AW-1:0], DW'($urandom_range(1, 255)));
      do_cycle(1'b0, 1'b1, 1'b0, 12'hFE1, 8'h3C);
      do_cycle(1'b1, 1'b0, 1'b1, 12'h056, 8'h00);
      repeat (100) idle_cycle();
      apply_reset(2);
      do_cycle(1'b1, 1'b0, 1'b0, 12'd0, 8'h00);
      do_cycle(1'b1, 1'b0, 1'b0, 12'd99, 8'h00);
      do_cycle(1'b1, 1'b0, 1'b0, 12'd100, 8'h00);
      do_cycle(1'b1, 1'b0, 1'b0, 12'd150, 8'h00);
      do_cycle(1'b1, 1'b0, 1'b0, 12'hFE1, 8'h00);
      idle_cycle();

      // Randomized traffic over a small address window, with occasional clears.
      normal = 0;
      guard  = 0;
      while (normal < 600 && guard < 20000) begin
         guard++;
         if (clr_left > 0) begin
            r = ($urandom_range(0, 9) == 0);
            w = ($urandom_range(0, 9) == 0);
            c = ($urandom_range(0, 19) == 0);
         end else begin
            normal++;
            r = $urandom_range(0, 1);
            w = $urandom_range(0, 1);
            c = ($urandom_range(0, 299) == 0);
         end
         a = AW'($urandom_range(0, 31));
         if ($urandom_range(0, 7) == 0) a = AW'($urandom);
         do_cycle(r, w, c, a, DW'($urandom));
      end
      idle_cycle();
      idle_cycle();
      @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d reads never answered, required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
